mem_access_ctrl: RTL and testbench

Memory-stage sequencer that sits behind the EX/MEM pipeline register and drives the data-memory port with a req/ack handshake. While an access is outstanding it freezes the pipeline with a stall. It also checks alignment, detects timeouts, and generates the branch-taken flush for the EX/MEM register.

---
 rtl/mem_access_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory-stage sequencer behind the EX/MEM register. Drives the data-memory
// req/ack port, stalls the pipeline while an access is outstanding, flags
// misaligned accesses and abandoned (timed-out) accesses, and produces the
// taken-branch flush for EX/MEM.
//
// Optional build macro: MEM_ACCESS_STATS_EN
//   When defined, adds stat_accesses / stat_stall_cycles counters and ports.
//
// TIMEOUT_CYCLES must be at least 2 and CNT_W must be wide enough to hold
// TIMEOUT_CYCLES (the counter is allowed to step to that value on the last
// REQ cycle before it is cleared in DONE).
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        branch,
    input  logic        zero,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  dmem_size,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        stall,
    output logic        exe_flush,
    output logic        misalign_exc,
    output logic        timeout_exc
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0] stat_accesses,
    output logic [31:0] stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Size of the access presented by EX/MEM; a write overrides a read.
    function automatic logic [1:0] access_size(input logic [1:0] rd,
                                               input logic [1:0] wr);
        logic [1:0] sz;
        if (wr != 2'b00) begin
            sz = wr;
        end else begin
            sz = rd;
        end
        return sz;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [1:0] sz,
                                           input logic [1:0] a_lo);
        logic mis;
        case (sz)
            2'b10:   mis = a_lo[0];
            2'b11:   mis = (a_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Registered state and outputs
    state_t            r_state;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [1:0]        r_dmem_size;
    logic [31:0]       r_dmem_addr;
    logic [31:0]       r_dmem_wdata;
    logic [31:0]       r_rdata_out;
    logic              r_rdata_valid;
    logic              r_misalign_exc;
    logic              r_timeout_exc;
    logic [CNT_W-1:0]  r_cnt;

    // Decoded request and next-state values
    logic              w_acc;
    logic              w_is_write;
    logic [1:0]        w_size;
    logic              w_misaligned;
    logic              w_timeout_hit;
    logic              w_stall;
    state_t            w_state_nxt;
    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [1:0]        w_size_nxt;
    logic [31:0]       w_addr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic [31:0]       w_rdata_nxt;
    logic              w_rv_nxt;
    logic              w_mis_nxt;
    logic              w_to_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_is_write    = (mem_write != 2'b00);
    assign w_acc         = w_is_write || (mem_read != 2'b00);
    assign w_size        = access_size(mem_read, mem_write);
    assign w_misaligned  = is_misaligned(w_size, addr[1:0]);
    assign w_timeout_hit = (r_cnt == CNT_LAST);

    // Next-state, next-register values and the combinational stall.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_dmem_req;
        w_we_nxt    = r_dmem_we;
        w_size_nxt  = r_dmem_size;
        w_addr_nxt  = r_dmem_addr;
        w_wdata_nxt = r_dmem_wdata;
        w_rdata_nxt = r_rdata_out;
        w_rv_nxt    = 1'b0;
        w_mis_nxt   = 1'b0;
        w_to_nxt    = 1'b0;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_stall     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (w_misaligned) begin
                        // No memory effect: let the instruction go, flag it.
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_REQ;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = w_is_write;
                        w_size_nxt  = w_size;
                        w_addr_nxt  = addr;
                        w_wdata_nxt = wdata;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_REQ: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (dmem_ack) begin
                    // Ack takes priority over a simultaneous timeout.
                    w_state_nxt = ST_DONE;
                    w_req_nxt   = 1'b0;
                    if (!r_dmem_we) begin
                        w_rv_nxt    = 1'b1;
                        w_rdata_nxt = dmem_rdata;
                    end else begin
                        w_rv_nxt    = 1'b0;
                    end
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_DONE;
                    w_req_nxt   = 1'b0;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end

            ST_DONE: begin
                // Pipeline advances on this edge; the access is never reissued.
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // State register and registered memory-port / pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_size    <= 2'b00;
            r_dmem_addr    <= 32'h0000_0000;
            r_dmem_wdata   <= 32'h0000_0000;
            r_rdata_out    <= 32'h0000_0000;
            r_rdata_valid  <= 1'b0;
            r_misalign_exc <= 1'b0;
            r_timeout_exc  <= 1'b0;
            r_cnt          <= {CNT_W{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_dmem_req     <= w_req_nxt;
            r_dmem_we      <= w_we_nxt;
            r_dmem_size    <= w_size_nxt;
            r_dmem_addr    <= w_addr_nxt;
            r_dmem_wdata   <= w_wdata_nxt;
            r_rdata_out    <= w_rdata_nxt;
            r_rdata_valid  <= w_rv_nxt;
            r_misalign_exc <= w_mis_nxt;
            r_timeout_exc  <= w_to_nxt;
            r_cnt          <= w_cnt_nxt;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic        w_done_entry;
    logic [31:0] r_stat_accesses;
    logic [31:0] r_stat_stall_cycles;

    assign w_done_entry = (r_state == ST_REQ) && (w_state_nxt == ST_DONE);

    // Free-running access and stall-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_accesses     <= 32'h0000_0000;
            r_stat_stall_cycles <= 32'h0000_0000;
        end else begin
            if (w_done_entry) begin
                r_stat_accesses <= r_stat_accesses + 32'd1;
            end else begin
                r_stat_accesses <= r_stat_accesses;
            end
            if (w_stall) begin
                r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
            end else begin
                r_stat_stall_cycles <= r_stat_stall_cycles;
            end
        end
    end

    assign stat_accesses     = r_stat_accesses;
    assign stat_stall_cycles = r_stat_stall_cycles;
`endif

    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_size    = r_dmem_size;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign rdata_out    = r_rdata_out;
    assign rdata_valid  = r_rdata_valid;
    assign misalign_exc = r_misalign_exc;
    assign timeout_exc  = r_timeout_exc;
    assign stall        = w_stall;
    assign exe_flush    = branch & zero & ~w_stall;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level reference model
// predicting each cycle's outputs, plus directed cases with literal values.
module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_read, mem_write;
    logic [31:0] addr, wdata, dmem_rdata;
    logic        branch, zero, dmem_ack;
    logic        dmem_req, dmem_we, rdata_valid, stall, exe_flush;
    logic        misalign_exc, timeout_exc;
    logic [1:0]  dmem_size;
    logic [31:0] dmem_addr, dmem_wdata, rdata_out;
`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] stat_accesses, stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) u_dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .branch(branch), .zero(zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid),
        .stall(stall), .exe_flush(exe_flush),
        .misalign_exc(misalign_exc), .timeout_exc(timeout_exc)
`ifdef MEM_ACCESS_STATS_EN
        , .stat_accesses(stat_accesses), .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [31:0] m_rdata;     // value rdata_out must hold
    bit          m_pend_mis;  // misalign pulse due this cycle
    int          m_acc_cnt;
    int          m_stall_cnt;

    // Per-transaction observed counts, used for literal checks
    int tx_stall, tx_req, tx_rv, tx_to, tx_mis, tx_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tx_clear();
        tx_stall = 0; tx_req = 0; tx_rv = 0; tx_to = 0; tx_mis = 0; tx_flush = 0;
    endtask

    // Inputs are already applied; sample at negedge, then advance to posedge+1.
    task automatic cycle(input bit e_stall, input bit e_req, input bit e_rv, input bit e_to,
                         input bit e_we, input logic [1:0] e_sz,
                         input logic [31:0] e_a, input logic [31:0] e_wd);
        @(negedge clk);
        n_vec++;
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("exe_flush", {31'd0, exe_flush}, {31'd0, branch & zero & ~e_stall});
        chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
        if (e_req) begin
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
            chk("dmem_size", {30'd0, dmem_size}, {30'd0, e_sz});
            chk("dmem_addr", dmem_addr, e_a);
            chk("dmem_wdata", dmem_wdata, e_wd);
        end
        chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, e_rv});
        chk("rdata_out", rdata_out, m_rdata);
        chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, m_pend_mis});
        chk("timeout_exc", {31'd0, timeout_exc}, {31'd0, e_to});
        m_pend_mis = 1'b0;
        if (e_stall) m_stall_cnt++;
        tx_stall += int'(stall);
        tx_req   += int'(dmem_req);
        tx_rv    += int'(rdata_valid);
        tx_to    += int'(timeout_exc);
        tx_mis   += int'(misalign_exc);
        tx_flush += int'(exe_flush);
        @(posedge clk);
        #1;
    endtask

    task automatic do_idle(input bit br, input bit z);
        mem_read = 2'b00; mem_write = 2'b00; addr = $urandom; wdata = $urandom;
        branch = br; zero = z; dmem_ack = 1'b0; dmem_rdata = $urandom;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    // ack_at: REQ cycle (1-based) carrying the ack; 0 or > TO means never.
    task automatic do_access(input bit is_wr, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_at,
                             input logic [31:0] rd, input bit br, input bit z);
        bit mis;
        bit acked;
        int n_req;
        mem_write = is_wr ? sz : 2'b00;
        mem_read  = is_wr ? 2'($urandom_range(0, 3)) : sz;
        addr = a; wdata = wd; branch = br; zero = z;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        mis   = (sz == 2'b10 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
        acked = (ack_at >= 1) && (ack_at <= TO);
        if (mis) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
            m_pend_mis = 1'b1;
        end else begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
            n_req = acked ? ack_at : TO;
            for (int k = 1; k <= n_req; k++) begin
                dmem_ack   = (k == ack_at);
                dmem_rdata = (k == ack_at) ? rd : $urandom;
                cycle(1'b1, 1'b1, 1'b0, 1'b0, is_wr, sz, a, wd);
            end
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (acked && !is_wr) m_rdata = rd;
            m_acc_cnt++;
            cycle(1'b0, 1'b0, acked && !is_wr, !acked, 1'b0, 2'b00, 32'd0, 32'd0);
        end
    endtask

    initial begin
        m_rdata = 32'd0; m_pend_mis = 1'b0; m_acc_cnt = 0; m_stall_cnt = 0;
        tx_clear();
        reset = 1'b1; mem_read = 2'b00; mem_write = 2'b00; addr = 32'd0; wdata = 32'd0;
        branch = 1'b0; zero = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_size", {30'd0, dmem_size}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_rv", {31'd0, rdata_valid}, 32'd0);
        chk("rst_mis", {31'd0, misalign_exc}, 32'd0);
        chk("rst_to", {31'd0, timeout_exc}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_idle(1'b0, 1'b0);

        // Word read, ack on first REQ cycle
        tx_clear();
        do_access(1'b0, 2'b11, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("wrd_stall_cycles", tx_stall, 2);
        chk("wrd_req_cycles", tx_req, 1);
        chk("wrd_rv_pulses", tx_rv, 1);
        chk("wrd_rdata", rdata_out, 32'hDEADBEEF);

        // Byte write, ack on 4th REQ cycle
        tx_clear();
        do_access(1'b1, 2'b01, 32'h103, 32'hAB, 4, 32'h0, 1'b0, 1'b0);
        chk("bwr_stall_cycles", tx_stall, 5);
        chk("bwr_req_cycles", tx_req, 4);
        chk("bwr_rv_pulses", tx_rv, 0);

        // Misaligned half read
        tx_clear();
        do_access(1'b0, 2'b10, 32'h101, 32'h0, 1, 32'h0, 1'b0, 1'b0);
        do_idle(1'b0, 1'b0);
        do_idle(1'b0, 1'b0);
        chk("mis_pulses", tx_mis, 1);
        chk("mis_stall_cycles", tx_stall, 0);
        chk("mis_req_cycles", tx_req, 0);

        // Timeout, never acked
        tx_clear();
        do_access(1'b0, 2'b11, 32'h200, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        chk("to_req_cycles", tx_req, 16);
        chk("to_pulses", tx_to, 1);
        chk("to_rv_pulses", tx_rv, 0);
        chk("to_stall_cycles", tx_stall, 17);

        // Ack arriving on the timeout cycle wins
        tx_clear();
        do_access(1'b0, 2'b10, 32'h202, 32'h0, TO, 32'h1234_5678, 1'b1, 1'b1);
        chk("acklast_to_pulses", tx_to, 0);
        chk("acklast_rv_pulses", tx_rv, 1);
        chk("acklast_flush", tx_flush, 1);

        // Branch flush
        tx_clear();
        do_idle(1'b1, 1'b1);
        chk("br_taken_flush", tx_flush, 1);
        tx_clear();
        do_idle(1'b1, 1'b0);
        chk("br_not_taken_flush", tx_flush, 0);

        // Reset during REQ after 3 cycles
        tx_clear();
        mem_read = 2'b11; mem_write = 2'b00; addr = 32'h300; wdata = 32'h0;
        branch = 1'b0; zero = 1'b0; dmem_ack = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h300, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h300, 32'h0);
        reset = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 32'h300, 32'h0);
        reset = 1'b0;
        m_rdata = 32'd0; m_pend_mis = 1'b0; m_acc_cnt = 0; m_stall_cnt = 0;
        do_idle(1'b0, 1'b0);
        do_idle(1'b0, 1'b0);
        chk("rst_mid_to_pulses", tx_to, 0);
        chk("rst_mid_rv_pulses", tx_rv, 0);
        chk("rst_mid_req_cycles", tx_req, 3);
        tx_clear();
        do_access(1'b0, 2'b11, 32'h104, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("post_rst_rdata", rdata_out, 32'hCAFE_F00D);
        chk("post_rst_stall_cycles", tx_stall, 3);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                do_idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                do_access(1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)), $urandom,
                          $urandom, $urandom_range(0, TO + 2), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        do_idle(1'b0, 1'b0);

`ifdef MEM_ACCESS_STATS_EN
        chk("stat_accesses", stat_accesses, 32'(m_acc_cnt));
        chk("stat_stall_cycles", stat_stall_cycles, 32'(m_stall_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
